// File: rtl/load_filter_pkg.sv
// load_filter_pkg
//   Shared types and constants for the load filter and the enabled-register
//   test cases it feeds.
//   - lf_state_t : filter FSM state encoding
//   - LF_WIDTH   : default sample / D_IN width
//   - LF_CNT_W   : default statistics counter width
//   - sat_inc()  : increment that sticks at the all-ones value of a given width
package load_filter_pkg;

    localparam int LF_WIDTH = 8;
    localparam int LF_CNT_W = 16;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        TRACK = 2'd1,
        IDLE  = 2'd2
    } lf_state_t;

    // Width-generic saturating increment; callers widen to 64 bits and
    // truncate the result back to their own width (width must be < 64).
    function automatic logic [63:0] sat_inc(input logic [63:0] value,
                                            input int unsigned width);
        logic [63:0] max_val;
        max_val = (64'd1 << width) - 64'd1;
        if (value >= max_val)
            return max_val;
        else
            return value + 64'd1;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// sat_counter
//   Up-counter that saturates at 2^CNT_W-1 instead of wrapping.
//   clk   : clock, rising edge
//   rst   : synchronous active-high clear
//   inc   : count one event this cycle
//   count : current count
module sat_counter
    import load_filter_pkg::*;
#(
    parameter int CNT_W = LF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst)
            count <= '0;
        else if (inc)
            count <= CNT_W'(sat_inc(64'(count), CNT_W));
    end

endmodule

// File: rtl/load_filter.sv
// load_filter
//   Sits in front of an enabled register and only pulses its load enable
//   when an accepted sample differs from the last value loaded, so the
//   register's clock can stay gated through runs of repeated samples.
//   Also raises an idle hint after IDLE_CYCLES load-free cycles and keeps
//   load / suppression statistics.
//
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset
//   in_valid   : sample present
//   in_data    : sample value
//   in_ready   : sample accepted this cycle (= ~hold)
//   hold       : downstream stall, blocks acceptance
//   invalidate : forget the shadow; next accepted sample always loads
//   D_IN       : data to downstream register (last loaded value)
//   en         : one-cycle load enable per load
//   idle       : no load for at least IDLE_CYCLES cycles
//   load_cnt   : loads issued (saturating)
//   supp_cnt   : accepted samples suppressed (saturating)
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   EMPTY | shadow invalid; next accepted sample loads, no idle timing
//   TRACK | shadow valid; idle timer running down between loads
//   IDLE  | timer expired, idle=1; held until a load or invalidate
module load_filter
    import load_filter_pkg::*;
#(
    parameter int WIDTH       = LF_WIDTH,
    parameter int CNT_W       = LF_CNT_W,
    parameter int IDLE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    input  logic             hold,
    input  logic             invalidate,
    output logic [WIDTH-1:0] D_IN,
    output logic             en,
    output logic             idle,
    output logic [CNT_W-1:0] load_cnt,
    output logic [CNT_W-1:0] supp_cnt
);

    localparam int TMR_W = (IDLE_CYCLES > 2) ? $clog2(IDLE_CYCLES) : 1;
    localparam logic [TMR_W-1:0] TMR_RELOAD = TMR_W'(IDLE_CYCLES - 1);

    lf_state_t        state;
    logic [WIDTH-1:0] shadow;
    logic [TMR_W-1:0] idle_tmr;
    logic             accept;
    logic             load;
    logic             suppress;

    assign in_ready = ~hold;
    assign accept   = in_valid & in_ready;

    // The shadow is only meaningful outside EMPTY, so state doubles as the
    // shadow-valid flag.
    assign load     = accept & ((state == EMPTY) | (in_data != shadow) | invalidate);
    assign suppress = accept & ~load;

    // Idle timer is a down-counter reloaded on every load; reaching zero on a
    // load-free cycle means IDLE_CYCLES load-free cycles have elapsed.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= EMPTY;
            shadow   <= '0;
            idle_tmr <= '0;
            D_IN     <= '0;
            en       <= 1'b0;
            idle     <= 1'b0;
        end else begin
            en <= load;
            if (load) begin
                D_IN   <= in_data;
                shadow <= in_data;
            end

            case (state)
                EMPTY: begin
                    idle <= 1'b0;
                    if (load) begin
                        state    <= TRACK;
                        idle_tmr <= TMR_RELOAD;
                    end
                end
                TRACK: begin
                    if (load) begin
                        idle_tmr <= TMR_RELOAD;
                        idle     <= 1'b0;
                    end else if (invalidate) begin
                        state <= EMPTY;
                        idle  <= 1'b0;
                    end else if (idle_tmr == '0) begin
                        state <= IDLE;
                        idle  <= 1'b1;
                    end else begin
                        idle_tmr <= idle_tmr - 1'b1;
                        idle     <= 1'b0;
                    end
                end
                IDLE: begin
                    if (load) begin
                        state    <= TRACK;
                        idle_tmr <= TMR_RELOAD;
                        idle     <= 1'b0;
                    end else if (invalidate) begin
                        state <= EMPTY;
                        idle  <= 1'b0;
                    end else begin
                        idle <= 1'b1;
                    end
                end
                default: begin
                    state <= EMPTY;
                    idle  <= 1'b0;
                end
            endcase
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_load_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (load),
        .count (load_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_supp_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (suppress),
        .count (supp_cnt)
    );

endmodule

// File: tb/tb_load_filter.sv
// tb_load_filter
//   Directed bench for load_filter. A second instance with 2-bit counters
//   shares the same stimulus and is checked only for counter saturation.
module tb_load_filter;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        hold;
    logic        invalidate;

    logic        in_ready, en, idle;
    logic [7:0]  d_in;
    logic [15:0] load_cnt, supp_cnt;

    logic        in_ready2, en2, idle2;
    logic [7:0]  d_in2;
    logic [1:0]  load_cnt2, supp_cnt2;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    load_filter #(.WIDTH(8), .CNT_W(16), .IDLE_CYCLES(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .hold       (hold),
        .invalidate (invalidate),
        .D_IN       (d_in),
        .en         (en),
        .idle       (idle),
        .load_cnt   (load_cnt),
        .supp_cnt   (supp_cnt)
    );

    load_filter #(.WIDTH(8), .CNT_W(2), .IDLE_CYCLES(4)) dut_sat (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready2),
        .hold       (hold),
        .invalidate (invalidate),
        .D_IN       (d_in2),
        .en         (en2),
        .idle       (idle2),
        .load_cnt   (load_cnt2),
        .supp_cnt   (supp_cnt2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are sampled there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_data    = 8'd0;
        hold       = 1'b0;
        invalidate = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic send(input logic [7:0] v);
        in_valid = 1'b1;
        in_data  = v;
        tick();
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = 8'd0; hold = 1'b0; invalidate = 1'b0;
        tick();
        tick();
        check("rst_d_in",     32'(d_in),     32'd0);
        check("rst_en",       32'(en),       32'd0);
        check("rst_idle",     32'(idle),     32'd0);
        check("rst_load_cnt", 32'(load_cnt), 32'd0);
        check("rst_supp_cnt", 32'(supp_cnt), 32'd0);
        rst = 1'b0;

        // First sample always loads; a repeat is suppressed.
        send(8'd1);
        check("t1_en",   32'(en),   32'd1);
        check("t1_d_in", 32'(d_in), 32'd1);
        send(8'd1);
        check("t1_rep_en",   32'(en),       32'd0);
        check("t1_rep_supp", 32'(supp_cnt), 32'd1);
        check("t1_rep_d_in", 32'(d_in),     32'd1);

        // Stream 3,13,13,13,254.
        do_reset();
        send(8'd3);   check("s_3_en",    32'(en), 32'd1);
        send(8'd13);  check("s_13a_en",  32'(en), 32'd1);
        send(8'd13);  check("s_13b_en",  32'(en), 32'd0);
        send(8'd13);  check("s_13c_en",  32'(en), 32'd0);
        send(8'd254); check("s_254_en",  32'(en), 32'd1);
        check("s_load_cnt", 32'(load_cnt), 32'd3);
        check("s_supp_cnt", 32'(supp_cnt), 32'd2);
        check("s_d_in",     32'(d_in),     32'd254);

        // Idle detection after loading 13.
        send(8'd13);
        check("i_load_en", 32'(en), 32'd1);
        in_valid = 1'b0;
        tick(); check("i_idle_c1", 32'(idle), 32'd0);
        tick(); check("i_idle_c2", 32'(idle), 32'd0);
        tick(); check("i_idle_c3", 32'(idle), 32'd0);
        tick(); check("i_idle_c4", 32'(idle), 32'd1);
        send(8'd13);
        check("i_supp_idle", 32'(idle),     32'd1);
        check("i_supp_en",   32'(en),       32'd0);
        check("i_supp_cnt",  32'(supp_cnt), 32'd3);
        send(8'd0);
        check("i_wake_en",   32'(en),   32'd1);
        check("i_wake_d_in", 32'(d_in), 32'd0);
        check("i_wake_idle", 32'(idle), 32'd0);

        // Invalidate together with an equal sample forces a load.
        send(8'd13);
        check("inv_pre_load", 32'(load_cnt), 32'd6);
        invalidate = 1'b1;
        send(8'd13);
        invalidate = 1'b0;
        check("inv_acc_en",   32'(en),       32'd1);
        check("inv_acc_load", 32'(load_cnt), 32'd7);
        send(8'd13);
        check("inv_track_en",   32'(en),       32'd0);
        check("inv_track_supp", 32'(supp_cnt), 32'd4);

        // Invalidate alone: D_IN kept, next equal sample loads.
        in_valid   = 1'b0;
        invalidate = 1'b1;
        tick();
        invalidate = 1'b0;
        check("inv_only_en",   32'(en),   32'd0);
        check("inv_only_d_in", 32'(d_in), 32'd13);
        send(8'd13);
        check("inv_after_en",   32'(en),       32'd1);
        check("inv_after_load", 32'(load_cnt), 32'd8);

        // Hold stalls acceptance.
        hold     = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'd7;
        #1;
        check("h_ready", 32'(in_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("h_en", 32'(en), 32'd0);
        end
        check("h_load_cnt", 32'(load_cnt), 32'd8);
        check("h_supp_cnt", 32'(supp_cnt), 32'd4);
        hold = 1'b0;
        #1;
        check("h_rel_ready", 32'(in_ready), 32'd1);
        tick();
        check("h_rel_en",   32'(en),   32'd1);
        check("h_rel_d_in", 32'(d_in), 32'd7);

        // Reset mid-stream drops the presented sample.
        rst      = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'd9;
        tick();
        rst = 1'b0;
        check("mr_d_in", 32'(d_in),     32'd0);
        check("mr_en",   32'(en),       32'd0);
        check("mr_idle", 32'(idle),     32'd0);
        check("mr_load", 32'(load_cnt), 32'd0);
        check("mr_supp", 32'(supp_cnt), 32'd0);
        send(8'd0);
        check("mr_zero_en",   32'(en),   32'd1);
        check("mr_zero_d_in", 32'(d_in), 32'd0);

        // Saturation on the 2-bit instance: five repeats, then four loads.
        for (int i = 0; i < 5; i++)
            send(8'd0);
        check("sat_supp2",     32'(supp_cnt2), 32'd3);
        check("sat_supp_wide", 32'(supp_cnt),  32'd5);
        send(8'd1);
        send(8'd2);
        send(8'd3);
        send(8'd4);
        check("sat_load2",     32'(load_cnt2), 32'd3);
        check("sat_load_wide", 32'(load_cnt),  32'd5);
        check("sat_d_in2",     32'(d_in2),     32'd4);

        in_valid = 1'b0;
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
